// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD control FSM and datapath among NREQ requesters.
// Define GCD_TIMEOUT_EN to add a WAIT-state watchdog that forces result=0 and err=1.
module gcd_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   op_a,
   input  logic [NREQ*WIDTH-1:0]   op_b,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [WIDTH-1:0]        result,
   output logic                    busy,
   output logic                    err,
   output logic [WIDTH-1:0]        gcd_a,
   output logic [WIDTH-1:0]        gcd_b,
   output logic                    gcd_in_ready,
   input  logic                    gcd_out_valid,
   input  logic [WIDTH-1:0]        gcd_result,
   output logic                    gcd_result_taken
);

   localparam int unsigned SelW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StWait   = 2'd2,
      StReturn = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [SelW-1:0]   sel_q, sel_d;
   logic [SelW-1:0]   last_q, last_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [WIDTH-1:0]  gcd_a_q, gcd_a_d;
   logic [WIDTH-1:0]  gcd_b_q, gcd_b_d;
   logic              in_ready_q, in_ready_d;
   logic              taken_q, taken_d;

   logic              found;
   logic [SelW-1:0]   pick;

`ifdef GCD_TIMEOUT_EN
   logic [7:0]        cnt_q, cnt_d;
   logic              to_q, to_d;
`else
   logic              unused_timeout;
   assign unused_timeout = |32'(TIMEOUT);
`endif

   // Search upward from last+1 with wrap, so the previous winner is considered last.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!found && req[(32'(last_q) + i) % NREQ]) begin
            found = 1'b1;
            pick  = SelW'((32'(last_q) + i) % NREQ);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      result_d   = result_q;
      err_d      = 1'b0;
      gcd_a_d    = gcd_a_q;
      gcd_b_d    = gcd_b_q;
      in_ready_d = 1'b0;
      taken_d    = 1'b0;
`ifdef GCD_TIMEOUT_EN
      cnt_d      = cnt_q;
      to_d       = to_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (found) begin
               sel_d       = pick;
               gcd_a_d     = op_a[32'(pick) * WIDTH +: WIDTH];
               gcd_b_d     = op_b[32'(pick) * WIDTH +: WIDTH];
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               in_ready_d  = 1'b1;
               state_d     = StIssue;
            end
         end
         StIssue: begin
`ifdef GCD_TIMEOUT_EN
            cnt_d = '0;
            to_d  = 1'b0;
`endif
            state_d = StWait;
         end
         StWait: begin
            if (gcd_out_valid) begin
               result_d = gcd_result;
               taken_d  = 1'b1;
               state_d  = StReturn;
            end
`ifdef GCD_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT - 1)) begin
               // Release the GCD FSM anyway so it returns to its idle state.
               result_d = '0;
               taken_d  = 1'b1;
               to_d     = 1'b1;
               state_d  = StReturn;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         StReturn: begin
            done_d        = '0;
            done_d[sel_q] = 1'b1;
`ifdef GCD_TIMEOUT_EN
            err_d         = to_q;
`endif
            gnt_d         = '0;
            last_d        = sel_q;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         last_q     <= SelW'(NREQ - 1);
         gnt_q      <= '0;
         done_q     <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         gcd_a_q    <= '0;
         gcd_b_q    <= '0;
         in_ready_q <= 1'b0;
         taken_q    <= 1'b0;
`ifdef GCD_TIMEOUT_EN
         cnt_q      <= '0;
         to_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         gcd_a_q    <= gcd_a_d;
         gcd_b_q    <= gcd_b_d;
         in_ready_q <= in_ready_d;
         taken_q    <= taken_d;
`ifdef GCD_TIMEOUT_EN
         cnt_q      <= cnt_d;
         to_q       <= to_d;
`endif
      end
   end

   assign gnt              = gnt_q;
   assign done             = done_q;
   assign result           = result_q;
   assign busy             = busy_q;
   assign gcd_a            = gcd_a_q;
   assign gcd_b            = gcd_b_q;
   assign gcd_in_ready     = in_ready_q;
   assign gcd_result_taken = taken_q;
`ifdef GCD_TIMEOUT_EN
   assign err              = err_q;
`else
   logic unused_err;
   assign unused_err = err_q;
   assign err        = 1'b0;
`endif

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Shares one GCD datapath/control pair among NREQ requesters using fair round-robin arbitration.
- Captures the winning requester's operands and drives the GCD unit's In_ready / Result_taken handshake.
- Returns the GCD result to the granted requester with a one-cycle done pulse.
- Sits between client logic and the existing GCD control FSM plus datapath.

Parameters:
- NREQ, 4: number of requesters; 2..8.
- WIDTH, 16: operand and result width in bits.
- TIMEOUT, 255: watchdog limit in cycles. Used only with GCD_TIMEOUT_EN.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- nrst, input, 1: asynchronous active-low reset.
- req, input, NREQ: per-requester request. Held high, with stable operands, until that requester's done pulse.
- op_a, input, NREQ*WIDTH: packed A operands; requester i uses bits [i*WIDTH +: WIDTH].
- op_b, input, NREQ*WIDTH: packed B operands, same packing as op_a.
- gnt, output, NREQ: one-hot; bit i high while requester i's job is in service.
- done, output, NREQ: one-hot, one-cycle pulse when requester i's result is on result.
- result, output, WIDTH: registered GCD result. Valid in the done cycle; holds its value until the next capture.
- busy, output, 1: high in any state other than IDLE.
- err, output, 1: one-cycle timeout flag, coincident with done. Tied 0 without GCD_TIMEOUT_EN.
- gcd_a, output, WIDTH: latched A operand presented to the GCD datapath.
- gcd_b, output, WIDTH: latched B operand presented to the GCD datapath.
- gcd_in_ready, output, 1: In_ready to the GCD control FSM.
- gcd_out_valid, input, 1: high while the GCD control FSM is in its DONE state.
- gcd_result, input, WIDTH: GCD result (A register value).
- gcd_result_taken, output, 1: Result_taken to the GCD control FSM.

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE.
  - gnt, done, result, busy, err, gcd_a, gcd_b, gcd_in_ready, gcd_result_taken all 0.
  - last-grant pointer = NREQ-1, so requester 0 has priority first.
- State machine, 2-bit: IDLE=0, ISSUE=1, WAIT=2, RETURN=3.
- IDLE:
  - If any req bit is high, select the first requester found searching upward, with wrap, from last+1.
  - Register sel; latch op_a[sel] into gcd_a and op_b[sel] into gcd_b; set gnt[sel]=1; go to ISSUE.
  - If no req bit is high, remain in IDLE.
- ISSUE:
  - gcd_in_ready=1 for exactly this one cycle; go to WAIT.
  - gcd_a and gcd_b stay stable until the next IDLE selection.
- WAIT:
  - gcd_in_ready=0.
  - When gcd_out_valid=1: capture gcd_result into result, pulse gcd_result_taken=1 for one cycle, go to RETURN.
- RETURN:
  - done[sel]=1 for one cycle; gnt cleared; last=sel; go to IDLE.
- Latency:
  - req sampled in IDLE at edge N: gnt visible after edge N, gcd_in_ready high in cycle N+1.
  - done arrives 2 cycles after the edge that sampled gcd_out_valid.
- Arbitration boundary conditions:
  - Simultaneous requests are served strictly round-robin; no requester waits more than NREQ-1 jobs.
  - Only one job is in flight; requests arriving during service wait.
  - req dropped mid-service: the job is not aborted; done still pulses and the result is still delivered.
  - A requester re-asserting req in its own done cycle gets lowest priority in the next IDLE.
  - Operand values are not inspected. B=0 and A<B cases are the GCD unit's responsibility and are forwarded unchanged.
- Reset mid-operation: immediate return to IDLE with reset outputs; the in-flight job is lost and no done is issued.

Optional Feature:
- Macro GCD_TIMEOUT_EN.
- Defined:
  - An 8-bit cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without gcd_out_valid: result=0, err=1 coincident with done[sel], gcd_result_taken pulsed, go to RETURN.
- Undefined: no counter; WAIT is unbounded; err is tied to 0.

Test Plan:
1. Reset, then req=4'b0001, op_a[0]=48, op_b[0]=18; GCD model returns 6 after 5 cycles -> gnt=0001, one gcd_in_ready pulse with gcd_a=48/gcd_b=18, then done=0001 with result=6, then busy=0.
2. req=4'b1111 held with distinct operands -> grant order 0,1,2,3,0; each done carries its own GCD (e.g. 35,14 -> 7).
3. After serving requester 2, req=4'b0101 -> next grant is requester 0 via wrap-around, not 2.
4. req[1] dropped during WAIT -> done[1] still pulses, result correct, and the next IDLE ignores requester 1.
5. nrst pulled low during WAIT -> all outputs 0 immediately, no done; a new req afterwards is served normally from requester 0 priority.
6. With GCD_TIMEOUT_EN and TIMEOUT=10, gcd_out_valid held 0 -> after 10 WAIT cycles done[sel]=1, err=1, result=0. Without the macro, the block stays in WAIT with busy=1.
